// File: rtl/conv_window_gen.sv
// Streaming KxK window generator: raster pixels in, one flattened "valid" window out per
// accepted pixel once the window is fully populated. Uses K_H-1 line buffers plus a column history.
module conv_window_gen #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int DATA_W = 9,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_pix,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [K_H*K_W*DATA_W-1:0]   win_data,
  output logic [RW-1:0]               win_row,
  output logic [CW-1:0]               win_col,
  output logic                        win_last
);

  localparam logic [0:0]    ST_FILL      = 1'b0;
  localparam logic [0:0]    ST_RUN       = 1'b1;
  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_EMIT     = CW'(K_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL_END = RW'(K_H - 2);

  logic [RW-1:0]                    r_row;
  logic [CW-1:0]                    r_col;
  logic [0:0]                       r_state;
  logic                             r_win_valid;
  logic                             r_win_last;
  logic [K_H*K_W*DATA_W-1:0]        r_win_data;
  logic [RW-1:0]                    r_win_row;
  logic [CW-1:0]                    r_win_col;
  // Columns 1..K_W-1 of the most recent window; they become columns 0..K_W-2 of the next one.
  logic [K_H*(K_W-1)*DATA_W-1:0]    r_hist;

  logic [DATA_W-1:0]                w_lb_rd [K_H-1];
  logic [DATA_W-1:0]                w_col_vec [K_H];
  logic [K_H*K_W*DATA_W-1:0]        w_win_flat;
  logic                             w_accept;
  logic                             w_emit;
  logic                             w_col_wrap;
  logic                             w_frame_end;

  assign in_ready    = !rst && (!r_win_valid || win_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_col_wrap  = (r_col == COL_LAST);
  assign w_frame_end = w_col_wrap && (r_row == ROW_LAST);
  assign w_emit      = (r_state == ST_RUN) && (r_col >= COL_EMIT);

  assign win_valid = r_win_valid;
  assign win_data  = r_win_data;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign win_last  = r_win_last;

  // lb[0] holds the previous row, lb[K_H-2] the oldest; each column shifts down on its own accept.
  generate
    for (genvar gi = 0; gi < K_H - 1; gi++) begin : gen_lb
      logic [DATA_W-1:0] r_mem [IMG_W];
      assign w_lb_rd[gi] = r_mem[r_col];
      if (gi == 0) begin : gen_first
        always_ff @(posedge clk) begin
          if (w_accept) r_mem[r_col] <= in_pix;
        end
      end else begin : gen_rest
        always_ff @(posedge clk) begin
          if (w_accept) r_mem[r_col] <= w_lb_rd[gi-1];
        end
      end
    end

    for (genvar gi = 0; gi < K_H; gi++) begin : gen_vec
      if (gi == K_H - 1) begin : gen_bottom
        assign w_col_vec[gi] = in_pix;
      end else begin : gen_upper
        assign w_col_vec[gi] = w_lb_rd[K_H-2-gi];
      end
      for (genvar gj = 0; gj < K_W; gj++) begin : gen_elem
        if (gj == K_W - 1) begin : gen_new
          assign w_win_flat[(gi*K_W+gj)*DATA_W +: DATA_W] = w_col_vec[gi];
        end else begin : gen_old
          assign w_win_flat[(gi*K_W+gj)*DATA_W +: DATA_W] = r_hist[(gi*(K_W-1)+gj)*DATA_W +: DATA_W];
        end
      end
      for (genvar gj = 0; gj < K_W - 1; gj++) begin : gen_hist
        always_ff @(posedge clk) begin
          if (w_accept)
            r_hist[(gi*(K_W-1)+gj)*DATA_W +: DATA_W] <= w_win_flat[(gi*K_W+gj+1)*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row       <= '0;
      r_col       <= '0;
      r_state     <= ST_FILL;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_win_data  <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      if (w_accept) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (w_frame_end)
          r_state <= ST_FILL;
        else if (w_col_wrap && r_row == ROW_FILL_END)
          r_state <= ST_RUN;
      end
      // A take with a simultaneous new window keeps win_valid high.
      if (w_accept && w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_win_flat;
        r_win_row   <= r_row;
        r_win_col   <= r_col;
        r_win_last  <= w_frame_end;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 frame: basic, backpressure, back-to-back,
// mid-frame reset, bit-extreme and gapped streams, all checked against a pixel-formula model.
module tb_conv_window_gen;
  localparam int W = 5;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [8:0]   in_pix = '0;
  logic         win_valid;
  logic         win_ready = 1'b0;
  logic [80:0]  win_data;
  logic [1:0]   win_row;
  logic [2:0]   win_col;
  logic         win_last;

  int pass_cnt = 0;
  int chk_cnt = 0;
  int first_acc;
  int viol;
  bit timeout;
  logic [8:0]  pix_q[$];
  logic [86:0] cap[$];

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .K_H(3), .K_W(3), .DATA_W(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pix_fn(int mode, int r, int c);
    if (mode == 2) return (((5*r + c) % 2) == 0) ? 9'h1FF : 9'h000;
    return 9'(5*r + c + ((mode == 1) ? 20 : 0));
  endfunction

  function automatic logic [80:0] exp_win(int mode, int r, int c);
    logic [80:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*9 +: 9] = pix_fn(mode, r - 2 + i, c - 2 + j);
    return w;
  endfunction

  function automatic logic [86:0] exp_cap(int mode, int k);
    int r = 2 + (k % 6) / 3;
    int c = 2 + (k % 6) % 3;
    return {exp_win(mode, r, c), 2'(r), 3'(c), ((k % 6) == 5)};
  endfunction

  task automatic load_frame(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pix_q.push_back(pix_fn(mode, r, c));
  endtask

  // Drives pix_q, records taken windows in cap and counts hold/backpressure violations.
  task automatic run_stream(input bit gaps, input bit stall_first);
    int sent = 0;
    int cyc = 0;
    int tail = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit prev_hold = 1'b0;
    logic [86:0] prev = '0;
    logic [86:0] now;
    first_acc = -1;
    viol = 0;
    timeout = 1'b0;
    while (tail < 4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      now = {win_data, win_row, win_col, win_last};
      if (prev_hold && (win_valid !== 1'b1 || now !== prev)) viol++;
      if (win_valid && first_acc < 0) first_acc = sent;
      if (stall_first && !stalled && win_valid) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else if (gaps && sent < pix_q.size()) begin
        win_ready = 1'($urandom_range(0, 1));
      end else begin
        win_ready = 1'b1;
      end
      if (win_valid && win_ready) begin
        cap.push_back(now);
        $display("win %0d: row=%0d col=%0d last=%0b data=%h", cap.size() - 1, win_row, win_col, win_last, win_data);
      end
      if (sent < pix_q.size() && (!gaps || $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_pix = pix_q[sent];
      end else begin
        in_valid = 1'b0;
        in_pix = 9'($urandom);
      end
      #1;
      if (win_valid && !win_ready && in_ready) viol++;
      if (in_valid && in_ready) sent++;
      prev_hold = win_valid && !win_ready;
      prev = now;
      if (sent == pix_q.size() && !win_valid) tail++;
    end
    in_valid = 1'b0;
    win_ready = 1'b1;
    if (cyc >= 2000) timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_pix = 9'h155;
    win_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    chk_cnt++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got=%b exp=0", win_valid); else pass_cnt++;
    chk_cnt++; if (win_data !== 81'd0) $display("FAIL reset_win_data got=%h exp=0", win_data); else pass_cnt++;
    chk_cnt++; if ({win_row, win_col, win_last} !== 6'd0) $display("FAIL reset_pos got=%h exp=0", {win_row, win_col, win_last}); else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b0;
    win_ready = 1'b1;
  endtask

  task automatic test_basic_frame();
    pix_q.delete(); cap.delete();
    load_frame(0);
    run_stream(1'b0, 1'b0);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL basic_timeout got=1 exp=0"); else pass_cnt++;
    chk_cnt++; if (cap.size() != 6) $display("FAIL basic_count got=%0d exp=6", cap.size()); else pass_cnt++;
    chk_cnt++; if (first_acc != 13) $display("FAIL basic_latency got=%0d exp=13", first_acc); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 6; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(0, k)) $display("FAIL basic_win%0d got=%h exp=%h", k, cap[k], exp_cap(0, k)); else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    pix_q.delete(); cap.delete();
    load_frame(0);
    run_stream(1'b0, 1'b1);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL bp_timeout got=1 exp=0"); else pass_cnt++;
    chk_cnt++; if (viol != 0) $display("FAIL bp_hold_violations got=%0d exp=0", viol); else pass_cnt++;
    chk_cnt++; if (cap.size() != 6) $display("FAIL bp_count got=%0d exp=6", cap.size()); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 6; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(0, k)) $display("FAIL bp_win%0d got=%h exp=%h", k, cap[k], exp_cap(0, k)); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    pix_q.delete(); cap.delete();
    load_frame(0);
    load_frame(1);
    run_stream(1'b0, 1'b0);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL b2b_timeout got=1 exp=0"); else pass_cnt++;
    chk_cnt++; if (cap.size() != 12) $display("FAIL b2b_count got=%0d exp=12", cap.size()); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 12; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(k / 6, k)) $display("FAIL b2b_win%0d got=%h exp=%h", k, cap[k], exp_cap(k / 6, k)); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    pix_q.delete(); cap.delete();
    load_frame(1);
    while (pix_q.size() > 7) void'(pix_q.pop_back());
    run_stream(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_pix = 9'h0AB;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (win_valid !== 1'b0) $display("FAIL rstmid_win_valid got=%b exp=0", win_valid); else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b0;
    pix_q.delete(); cap.delete();
    load_frame(0);
    run_stream(1'b0, 1'b0);
    chk_cnt++; if (first_acc != 13) $display("FAIL rstmid_latency got=%0d exp=13", first_acc); else pass_cnt++;
    chk_cnt++; if (cap.size() != 6) $display("FAIL rstmid_count got=%0d exp=6", cap.size()); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 6; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(0, k)) $display("FAIL rstmid_win%0d got=%h exp=%h", k, cap[k], exp_cap(0, k)); else pass_cnt++;
    end
  endtask

  task automatic test_extremes();
    pix_q.delete(); cap.delete();
    load_frame(2);
    run_stream(1'b0, 1'b0);
    chk_cnt++; if (cap.size() != 6) $display("FAIL ext_count got=%0d exp=6", cap.size()); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 6; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(2, k)) $display("FAIL ext_win%0d got=%h exp=%h", k, cap[k], exp_cap(2, k)); else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    pix_q.delete(); cap.delete();
    load_frame(0);
    load_frame(1);
    run_stream(1'b1, 1'b0);
    chk_cnt++; if (timeout !== 1'b0) $display("FAIL gaps_timeout got=1 exp=0"); else pass_cnt++;
    chk_cnt++; if (viol != 0) $display("FAIL gaps_hold_violations got=%0d exp=0", viol); else pass_cnt++;
    chk_cnt++; if (cap.size() != 12) $display("FAIL gaps_count got=%0d exp=12", cap.size()); else pass_cnt++;
    for (int k = 0; k < cap.size() && k < 12; k++) begin
      chk_cnt++; if (cap[k] !== exp_cap(k / 6, k)) $display("FAIL gaps_win%0d got=%h exp=%h", k, cap[k], exp_cap(k / 6, k)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_extremes();
    test_gaps();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
